// File: rtl/uart_rx_arbiter.sv
// uart_rx_arbiter: frame-aware arbiter that merges several idle-high UART TX lines
// into a single master RX line. It locks onto the first source that shows a start
// edge, forwards only that line for a whole frame plus any back-to-back frames, and
// flags start edges on every other source as collisions.
//
// Optional build macro: UART_RX_ARB_STUCK_MASK_EN
//   Adds per-source stuck-low detection, a stuck_mask output port, and a forced
//   release of the lock when the locked source is stuck low.

module uart_rx_arbiter #(
    parameter int unsigned N_SRC        = 3,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FRAME_BITS   = 10,
    parameter int unsigned GUARD_BITS   = 2,
    parameter int unsigned STUCK_BITS   = 40,
    localparam int unsigned SRC_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] src_tx,
    output logic             master_rx,
    output logic             busy,
    output logic [SRC_W-1:0] active_src,
    output logic             collision,
    output logic [N_SRC-1:0] coll_sticky
`ifdef UART_RX_ARB_STUCK_MASK_EN
    ,
    output logic [N_SRC-1:0] stuck_mask
`endif
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int unsigned LOCK_CYC  = CLKS_PER_BIT * FRAME_BITS;
    localparam int unsigned GUARD_CYC = CLKS_PER_BIT * GUARD_BITS;
    localparam int unsigned CNT_MAX   = (LOCK_CYC > GUARD_CYC) ? LOCK_CYC : GUARD_CYC;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LOCK_TC  = CNT_W'(LOCK_CYC - 1);
    localparam logic [CNT_W-1:0] GUARD_TC = CNT_W'(GUARD_CYC - 1);

    // Zero-sized counters or frames make no sense; stop elaboration early.
    if (N_SRC < 1 || CLKS_PER_BIT < 1 || FRAME_BITS < 1 || GUARD_BITS < 1 ||
        STUCK_BITS < 1) begin : g_param_check
        $error("uart_rx_arbiter: all parameters must be non-zero");
    end

    typedef enum logic [1:0] {
        StIdle,
        StLock,
        StGuard
    } state_e;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [N_SRC-1:0] r_meta;
    logic [N_SRC-1:0] r_sync;
    logic [N_SRC-1:0] r_prev;
    logic [N_SRC-1:0] w_fall;
    logic [N_SRC-1:0] w_mask;
    logic [N_SRC-1:0] w_fall_eff;

    logic             w_pick_vld;
    logic [SRC_W-1:0] w_pick_idx;
    logic [N_SRC-1:0] w_pick_oh;
    logic [N_SRC-1:0] w_act_oh;
    logic             w_act_sync;

    state_e           r_state;
    state_e           w_state_d;
    logic [SRC_W-1:0] r_active;
    logic [SRC_W-1:0] w_active_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic [N_SRC-1:0] w_coll_vec;

    logic             r_master_rx;
    logic             w_master_rx_d;
    logic             r_collision;
    logic [N_SRC-1:0] r_coll_sticky;

    // ------------------------------------------------------------------------
    // Input path
    // ------------------------------------------------------------------------
    // Two-flop synchronizer plus one delay flop for edge detection; all idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
            r_prev <= '1;
        end else begin
            r_meta <= src_tx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign w_fall     = r_prev & ~r_sync;
    assign w_fall_eff = w_fall & ~w_mask;

    // ------------------------------------------------------------------------
    // Optional stuck-low masking
    // ------------------------------------------------------------------------
`ifdef UART_RX_ARB_STUCK_MASK_EN
    localparam int unsigned STUCK_CYC = CLKS_PER_BIT * STUCK_BITS;
    localparam int unsigned RUN_W     = $clog2(STUCK_CYC + 1);

    logic [RUN_W-1:0] r_run   [N_SRC];
    logic [RUN_W-1:0] w_run_d [N_SRC];
    logic [N_SRC-1:0] r_mask;
    logic [N_SRC-1:0] w_mask_d;

    // Run-length of the current synchronized level per source, saturating.
    always_comb begin
        for (int i = 0; i < int'(N_SRC); i++) begin
            w_run_d[i]  = r_run[i];
            w_mask_d[i] = r_mask[i];
            if (r_sync[i] != r_prev[i]) begin
                w_run_d[i] = RUN_W'(1);
            end else if (r_run[i] != RUN_W'(STUCK_CYC)) begin
                w_run_d[i] = r_run[i] + RUN_W'(1);
            end
            if (!r_sync[i] && (w_run_d[i] == RUN_W'(STUCK_CYC))) begin
                w_mask_d[i] = 1'b1;
            end
            if (r_sync[i] && (w_run_d[i] >= RUN_W'(CLKS_PER_BIT))) begin
                w_mask_d[i] = 1'b0;
            end
        end
    end

    // Run counters and mask bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_SRC); i++) begin
                r_run[i] <= '0;
            end
            r_mask <= '0;
        end else begin
            for (int i = 0; i < int'(N_SRC); i++) begin
                r_run[i] <= w_run_d[i];
            end
            r_mask <= w_mask_d;
        end
    end

    assign w_mask     = r_mask;
    assign stuck_mask = r_mask;
`else
    assign w_mask = '0;
`endif

    // ------------------------------------------------------------------------
    // Arbitration helpers
    // ------------------------------------------------------------------------
    // Lowest-index start edge wins; one-hot views of the winner and the lock.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (w_fall_eff[i]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = SRC_W'(i);
            end
        end
        for (int i = 0; i < int'(N_SRC); i++) begin
            w_pick_oh[i] = (w_pick_idx == SRC_W'(i));
            w_act_oh[i]  = (r_active == SRC_W'(i));
        end
    end

    assign w_act_sync = r_sync[r_active];

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // State register, lock index and shared frame/idle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_active <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_d;
            r_active <= w_active_d;
            r_cnt    <= w_cnt_d;
        end
    end

    // Next-state, counter and collision decode.
    always_comb begin
        w_state_d  = r_state;
        w_active_d = r_active;
        w_cnt_d    = r_cnt;
        w_coll_vec = '0;

        case (r_state)
            StIdle: begin
                if (w_pick_vld) begin
                    w_state_d  = StLock;
                    w_active_d = w_pick_idx;
                    w_cnt_d    = '0;
                    // Losers of a same-cycle race count as collisions.
                    w_coll_vec = w_fall_eff & ~w_pick_oh;
                end
            end

            StLock: begin
                w_coll_vec = w_fall_eff & ~w_act_oh;
                // Line level is ignored here so a bad frame still runs to length.
                if (r_cnt == LOCK_TC) begin
                    w_state_d = StGuard;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end

            StGuard: begin
                w_coll_vec = w_fall_eff & ~w_act_oh;
                if (!w_act_sync) begin
                    // Back-to-back frame on the same source: keep the lock.
                    w_state_d = StLock;
                    w_cnt_d   = '0;
                end else if (r_cnt == GUARD_TC) begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
            end
        endcase

`ifdef UART_RX_ARB_STUCK_MASK_EN
        // A stuck locked source would otherwise hold the lock forever.
        if ((r_state != StIdle) && w_mask_d[r_active]) begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
        end
`endif
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Forward the edge-detect flop (sync delayed by one) so every bit, including
    // the start bit, keeps its width; idle drives high.
    assign w_master_rx_d = (w_state_d == StIdle) ? 1'b1 : r_prev[w_active_d];

    // Registered serial output and collision reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_master_rx   <= 1'b1;
            r_collision   <= 1'b0;
            r_coll_sticky <= '0;
        end else begin
            r_master_rx   <= w_master_rx_d;
            r_collision   <= |w_coll_vec;
            r_coll_sticky <= r_coll_sticky | w_coll_vec;
        end
    end

    assign master_rx   = r_master_rx;
    assign busy        = (r_state != StIdle);
    assign active_src  = r_active;
    assign collision   = r_collision;
    assign coll_sticky = r_coll_sticky;

endmodule
